// File: rtl/byte_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in over valid/ready, one bit per clock out, LSB first.
// A one-word holding register lets consecutive words stream with no idle bit between them.
//
// state | meaning
// IDLE  | nothing being shifted; o_a and o_frame held low
// SHIFT | sh_q[0] is on o_a; cnt_q is the index of the bit being sent
module byte_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_a,
  output logic             o_frame,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;

  assign accept = i_valid & o_ready;

  // Accept needs an empty hold register and a load needs a full one, so they never collide.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;

    if (accept) begin
      hold_d   = i_data;
      hold_v_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_v_q) begin
          sh_d     = hold_q;
          cnt_d    = '0;
          hold_v_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + CW'(1);
        end else if (hold_v_q) begin
          sh_d     = hold_q;
          cnt_d    = '0;
          hold_v_d = 1'b0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode directly from flops so reset clears them without waiting for a clock.
  assign o_ready = i_rst_n & ~hold_v_q;
  assign o_a     = (state_q == SHIFT) & sh_q[0];
  assign o_frame = (state_q == SHIFT) & (cnt_q == '0);
  assign o_busy  = (state_q == SHIFT) | hold_v_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: WIDTH=8 instance against a word-timing reference model,
// plus a WIDTH=2 instance streamed with a short directed sequence.
module tb_byte_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data;
  logic         valid;
  logic         ready, a, frame, busy;

  logic [1:0]   data2;
  logic         valid2;
  logic         ready2, a2, frame2, busy2;

  byte_serializer #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_a(a), .o_frame(frame), .o_busy(busy)
  );

  byte_serializer #(.WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data2), .i_valid(valid2),
    .o_ready(ready2), .o_a(a2), .o_frame(frame2), .o_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each accepted word n has accept edge qa, load edge ql.
  // Load edge = max(accept+1, previous load + W); bit k is on o_a after edge ql+k.
  int           qa[$];
  int           ql[$];
  logic [W-1:0] qw[$];
  int           last_l = -1000;
  int           cyc = 0;
  logic         accepted;
  logic [W-1:0] pend[$];

  logic [W-1:0] sent[$];
  logic [W-1:0] cap;
  int           idx = 99;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_eval(input int e, output logic r, output logic av,
                            output logic fv, output logic bv);
    logic hold, shift;
    hold = 1'b0; shift = 1'b0; av = 1'b0; fv = 1'b0;
    for (int n = 0; n < qa.size(); n++) begin
      if (qa[n] <= e && e < ql[n]) hold = 1'b1;
      if (ql[n] <= e && e < ql[n] + W) begin
        shift = 1'b1;
        av    = qw[n][e - ql[n]];
        fv    = (e == ql[n]);
      end
    end
    r  = rst_n & ~hold;
    bv = hold | shift;
  endtask

  task automatic model_clear();
    qa.delete(); ql.delete(); qw.delete(); sent.delete();
    last_l = -1000;
    idx = 99;
  endtask

  task automatic check_now();
    logic r, av, fv, bv;
    logic [W-1:0] exp_w;
    while (qa.size() > 0 && cyc >= ql[0] + W) begin
      void'(qa.pop_front()); void'(ql.pop_front()); void'(qw.pop_front());
    end
    model_eval(cyc, r, av, fv, bv);
    chk("o_ready", ready, r);
    chk("o_a", a, av);
    chk("o_frame", frame, fv);
    chk("o_busy", busy, bv);
    // Downstream-style capture: align on o_frame, collect W bits, compare with the sent word.
    if (frame) idx = 0;
    if (idx < W) begin
      cap[idx] = a;
      idx++;
      if (idx == W) begin
        exp_w = (sent.size() > 0) ? sent.pop_front() : ~cap;
        chk("captured_word", cap, exp_w);
      end
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d);
    logic r, av, fv, bv;
    int l;
    valid = v;
    data  = d;
    model_eval(cyc, r, av, fv, bv);
    accepted = v & r;
    @(posedge clk);
    cyc++;
    if (accepted) begin
      l = (cyc + 1 > last_l + W) ? cyc + 1 : last_l + W;
      qa.push_back(cyc); ql.push_back(l); qw.push_back(d);
      sent.push_back(d);
      last_l = l;
    end
    @(negedge clk);
    check_now();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, W'($urandom));
  endtask

  task automatic stream();
    for (int k = 0; k < 64 && pend.size() > 0; k++) begin
      step(1'b1, pend[0]);
      if (accepted) void'(pend.pop_front());
    end
    chk("stream_drained", pend.size(), 0);
    valid = 1'b0;
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_o_a", a, 0);
    chk("rst_o_frame", frame, 0);
    chk("rst_o_busy", busy, 0);
    chk("rst_o_ready", ready, 0);
    model_clear();
    repeat (2) begin
      @(posedge clk); cyc++;
      @(negedge clk); check_now();
    end
    rst_n = 1'b1;
  endtask

  logic [1:0] w2s [3];

  initial begin
    rst_n = 1'b0; valid = 1'b0; data = '0; valid2 = 1'b0; data2 = '0;
    #1;
    chk("por_o_ready", ready, 0);
    chk("por_o_busy", busy, 0);
    repeat (3) begin
      @(posedge clk); cyc++;
      @(negedge clk); check_now();
    end
    rst_n = 1'b1;

    // Single word
    pend.push_back(8'hA5); stream(); idle(11);
    // Back-to-back with valid held high
    pend.push_back(8'h01); pend.push_back(8'h80); pend.push_back(8'hFF);
    stream(); idle(12);
    // Late second word leaves a gap
    pend.push_back(8'h3C); stream(); idle(11);
    pend.push_back(8'hC3); stream(); idle(10);
    // Reset after bit 3 of F0 while 0F is held
    pend.push_back(8'hF0); pend.push_back(8'h0F); stream(); idle(2);
    reset_pulse();
    pend.push_back(8'h55); stream(); idle(10);
    chk("sent_after_55", sent.size(), 0);
    // Loopback word
    pend.push_back(8'h96); stream(); idle(10);
    chk("sent_after_96", sent.size(), 0);
    // Random traffic
    repeat (400) step($urandom_range(0, 99) < 60, W'($urandom));
    valid = 1'b0;
    idle(2 * W + 4);
    chk("sent_after_random", sent.size(), 0);

    // WIDTH=2 gapless stream: 01, 10, 11
    w2s[0] = 2'b01; w2s[1] = 2'b10; w2s[2] = 2'b11;
    valid2 = 1'b1; data2 = w2s[0];
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 5) data2 = w2s[k / 2];
      if (k == 5) valid2 = 1'b0;
      if (k == 1) chk("w2_ready_after_accept", ready2, 0);
      if (k >= 2 && k <= 7) begin
        chk("w2_o_a", a2, w2s[(k - 2) / 2][(k - 2) % 2]);
        chk("w2_o_frame", frame2, ((k - 2) % 2) == 0);
      end
      if (k == 8) begin
        chk("w2_busy_end", busy2, 0);
        chk("w2_ready_end", ready2, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
